// File: rtl/tdm_pkg.sv
// Shared definitions for the 4:1 TDM link (receive demux and transmit mux).
package tdm_pkg;

   localparam int TDM_SLOTS = 4;

   typedef logic [1:0] tdm_slot_t;

   typedef enum logic [1:0] {
      TDM_HUNT   = 2'd0,
      TDM_LOCKED = 2'd1
   } tdm_state_e;

endpackage

// File: rtl/tdm_slot_ctr.sv
// Slot alignment for the TDM receiver: slot counter, sync-miss counter and
// HUNT/LOCKED FSM, producing the capture and publish strobes for the datapath.
module tdm_slot_ctr
   import tdm_pkg::*;
#(
   parameter int MISS_MAX = 2
) (
   input  logic      clk,
   input  logic      rst_n,
   input  logic      en,
   input  logic      sync,
   output tdm_slot_t slot,
   output logic      locked,
   output logic      realign,
   output logic      store,
   output logic      publish,
   output logic      sync_err
);

   localparam logic [2:0] MISS_LIM = 3'(MISS_MAX);

   tdm_state_e state, state_d;
   tdm_slot_t  slot_d;
   logic [2:0] miss, miss_d, miss_inc;
   logic       sync_err_d;

   assign locked   = (state == TDM_LOCKED);
   assign miss_inc = miss + 3'd1;

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the values from before this edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= TDM_HUNT;
         slot     <= '0;
         miss     <= '0;
         sync_err <= 1'b0;
      end else begin
         state    <= state_d;
         slot     <= slot_d;
         miss     <= miss_d;
         sync_err <= sync_err_d;
      end
   end

   // NOTE: every output of this block gets a default first; a missed branch
   // would otherwise infer a latch.
   always_comb begin
      state_d    = state;
      slot_d     = slot;
      miss_d     = miss;
      sync_err_d = 1'b0;
      realign    = 1'b0;
      store      = 1'b0;
      publish    = 1'b0;

      if (en) begin
         unique case (state)
            TDM_HUNT: begin
               if (sync) begin
                  realign = 1'b1;
                  slot_d  = 2'd1;
                  miss_d  = '0;
                  state_d = TDM_LOCKED;
               end
            end
            TDM_LOCKED: begin
               if (sync && slot != 2'd0) begin
                  // Misplaced sync wins over a pending publish: the partial frame is dropped.
                  sync_err_d = 1'b1;
                  realign    = 1'b1;
                  slot_d     = 2'd1;
                  miss_d     = '0;
               end else begin
                  unique case (slot)
                     2'd0: begin
                        if (sync) begin
                           realign = 1'b1;
                           slot_d  = 2'd1;
                           miss_d  = '0;
                        end else if (miss_inc >= MISS_LIM) begin
                           state_d    = TDM_HUNT;
                           slot_d     = 2'd0;
                           miss_d     = '0;
                           sync_err_d = 1'b1;
                        end else begin
                           realign = 1'b1;
                           slot_d  = 2'd1;
                           miss_d  = miss_inc;
                        end
                     end
                     2'd1, 2'd2: begin
                        store  = 1'b1;
                        slot_d = slot + 2'd1;
                     end
                     default: begin
                        publish = 1'b1;
                        slot_d  = 2'd0;
                     end
                  endcase
               end
            end
            default: state_d = TDM_HUNT;
         endcase
      end
   end

endmodule

// File: rtl/tdm_demux4.sv
// Four-channel TDM receiver: captures slots 0..2 into a shadow buffer and
// publishes all four channels together when slot 3 arrives.
module tdm_demux4
   import tdm_pkg::*;
#(
   parameter int W        = 1,
   parameter int MISS_MAX = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         en,
   input  logic         sync,
   input  logic [W-1:0] din,
   output logic [W-1:0] y0,
   output logic [W-1:0] y1,
   output logic [W-1:0] y2,
   output logic [W-1:0] y3,
   output logic         frame_vld,
   output logic [1:0]   slot,
   output logic         locked,
   output logic         sync_err
);

   // Slot 3 bypasses straight to y3, so only three shadow entries are kept.
   logic [W-1:0] shadow [TDM_SLOTS-1];
   logic         realign, store, publish;

   tdm_slot_ctr #(
      .MISS_MAX(MISS_MAX)
   ) u_slot_ctr (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (en),
      .sync    (sync),
      .slot    (slot),
      .locked  (locked),
      .realign (realign),
      .store   (store),
      .publish (publish),
      .sync_err(sync_err)
   );

   // NOTE: the shadow buffer is a handful of flops, not a RAM, so it is reset
   // along with everything else to give a defined first frame.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < TDM_SLOTS - 1; i++) shadow[i] <= '0;
         y0        <= '0;
         y1        <= '0;
         y2        <= '0;
         y3        <= '0;
         frame_vld <= 1'b0;
      end else begin
         frame_vld <= publish;
         if (realign) shadow[0] <= din;
         if (store) begin
            if (slot == 2'd1) shadow[1] <= din;
            else              shadow[2] <= din;
         end
         if (publish) begin
            y0 <= shadow[0];
            y1 <= shadow[1];
            y2 <= shadow[2];
            y3 <= din;
         end
      end
   end

endmodule
